// File: rtl/ec_control_unit.sv
// Sequencing FSM for the 8-bit accumulator datapath: start/fetch/decode/execute,
// with IN stalled on Enter, HALT absorbing, and a retired-instruction counter.
module ec_control_unit #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [2:0]             IR,
  input  logic                   Aeq0,
  input  logic                   Apos,
  input  logic                   Enter,
  output logic                   IRload,
  output logic                   JMPmux,
  output logic                   PCload,
  output logic                   Meminst,
  output logic                   MemWr,
  output logic [1:0]             Asel,
  output logic                   Aload,
  output logic                   Sub,
  output logic                   Halt,
  output logic [3:0]             State,
  output logic [COUNT_WIDTH-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd8,
    S_STORE  = 4'd9,
    S_ADD    = 4'd10,
    S_SUB    = 4'd11,
    S_IN     = 4'd12,
    S_JZ     = 4'd13,
    S_JPOS   = 4'd14,
    S_HALT   = 4'd15
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_retire;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_irload, r_jmpmux, r_pcload, r_meminst, r_memwr;
  logic                   r_aload, r_sub, r_halt;
  logic [1:0]             r_asel;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START:  w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = state_t'({1'b1, IR});
      S_IN:     w_next = Enter ? S_START : S_IN;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_START;
    endcase
  end

  assign w_retire = r_state[3] && (r_state != S_HALT) && (w_next == S_START);

  // Moore outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_START;
      r_count   <= '0;
      r_irload  <= 1'b0;
      r_jmpmux  <= 1'b0;
      r_pcload  <= 1'b0;
      r_meminst <= 1'b0;
      r_memwr   <= 1'b0;
      r_asel    <= 2'b00;
      r_aload   <= 1'b0;
      r_sub     <= 1'b0;
      r_halt    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + COUNT_WIDTH'(1);
      r_irload  <= 1'b0;
      r_jmpmux  <= 1'b0;
      r_pcload  <= 1'b0;
      r_meminst <= 1'b0;
      r_memwr   <= 1'b0;
      r_asel    <= 2'b00;
      r_aload   <= 1'b0;
      r_sub     <= 1'b0;
      r_halt    <= 1'b0;
      case (w_next)
        S_FETCH:  begin r_irload <= 1'b1; r_pcload <= 1'b1; end
        S_DECODE: r_meminst <= 1'b1;
        S_LOAD:   begin r_aload <= 1'b1; r_asel <= 2'b10; end
        S_STORE:  begin r_meminst <= 1'b1; r_memwr <= 1'b1; end
        S_ADD:    r_aload <= 1'b1;
        S_SUB:    begin r_aload <= 1'b1; r_sub <= 1'b1; end
        S_IN:     r_asel <= 2'b01;
        S_JZ:     r_jmpmux <= 1'b1;
        S_JPOS:   r_jmpmux <= 1'b1;
        S_HALT:   r_halt <= 1'b1;
        default:  ;
      endcase
    end
  end

  // Mealy terms: A loads on the Enter cycle of IN, PC loads on a taken jump.
  assign Aload      = r_aload | ((r_state == S_IN) & Enter);
  assign PCload     = r_pcload | ((r_state == S_JZ) & Aeq0) | ((r_state == S_JPOS) & Apos);
  assign IRload     = r_irload;
  assign JMPmux     = r_jmpmux;
  assign Meminst    = r_meminst;
  assign MemWr      = r_memwr;
  assign Asel       = r_asel;
  assign Sub        = r_sub;
  assign Halt       = r_halt;
  assign State      = r_state;
  assign InstrCount = r_count;

endmodule

// File: tb/tb_ec_control_unit.sv
// Bench for ec_control_unit: directed instruction scenarios plus a random
// instruction stream, every cycle compared against a rule-based model.
module tb_ec_control_unit;

  logic       Clock, Reset, Aeq0, Apos, Enter;
  logic [2:0] IR;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] State;
  logic [7:0] InstrCount;

  int checks   = 0;
  int failures = 0;
  int m_state  = -1;   // unknown until the first reset
  int m_count  = 0;

  ec_control_unit #(.COUNT_WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst),
    .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .Sub(Sub), .Halt(Halt),
    .State(State), .InstrCount(InstrCount)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt}
  function automatic logic [9:0] exp_out(input int s, input logic eq, input logic ps,
                                         input logic en);
    logic irl, jmp, pcl, mi, mw, al, sb, hl;
    logic [1:0] as;
    irl = (s == 1);
    jmp = (s == 13) || (s == 14);
    pcl = (s == 1) || (s == 13 && eq) || (s == 14 && ps);
    mi  = (s == 2) || (s == 9);
    mw  = (s == 9);
    as  = (s == 8) ? 2'b10 : (s == 12) ? 2'b01 : 2'b00;
    al  = (s == 8) || (s == 10) || (s == 11) || (s == 12 && en);
    sb  = (s == 11);
    hl  = (s == 15);
    return {irl, jmp, pcl, mi, mw, as, al, sb, hl};
  endfunction

  task automatic cyc(input logic rst, input logic [2:0] ir, input logic eq,
                     input logic ps, input logic en);
    logic [9:0] exp_v, obs_v;
    Reset = rst; IR = ir; Aeq0 = eq; Apos = ps; Enter = en;
    @(negedge Clock);
    if (m_state >= 0) begin
      exp_v = exp_out(m_state, eq, ps, en);
      obs_v = {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt};
      checks++;
      assert (obs_v === exp_v) else begin
        failures++;
        $error("FAIL outputs state=%0d obs=%b exp=%b", m_state, obs_v, exp_v);
      end
      checks++;
      assert (State === 4'(m_state)) else begin
        failures++;
        $error("FAIL state obs=%0d exp=%0d", State, m_state);
      end
      checks++;
      assert (InstrCount === 8'(m_count)) else begin
        failures++;
        $error("FAIL count obs=%0d exp=%0d", InstrCount, m_count);
      end
    end
    @(posedge Clock);
    if (rst) begin
      m_state = 0;
      m_count = 0;
    end else if (m_state == 0) m_state = 1;
    else if (m_state == 1) m_state = 2;
    else if (m_state == 2) m_state = 8 + int'(ir);
    else if (m_state == 15) m_state = 15;
    else if (m_state == 12 && !en) m_state = 12;
    else if (m_state >= 8) begin
      m_state = 0;
      m_count = (m_count + 1) % 256;
    end
    #1;
  endtask

  // One full instruction from START; for IN, 'waits' Enter-low cycles precede the key.
  task automatic instr(input logic [2:0] op, input logic eq, input logic ps, input int waits);
    cyc(0, 3'($urandom), 0, 0, 1'($urandom));
    cyc(0, 3'($urandom), 0, 0, 1'($urandom));
    cyc(0, op, 0, 0, 1'($urandom));
    if (op == 3'd4) begin
      for (int i = 0; i < waits; i++) cyc(0, 3'($urandom), eq, ps, 0);
      cyc(0, 3'($urandom), eq, ps, 1);
    end else begin
      cyc(0, 3'($urandom), eq, ps, 1'($urandom));
    end
  endtask

  initial begin
    Reset = 1'b1; IR = 3'd0; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // STORE, IN with 5-cycle wait, IN with Enter already high, jumps both ways
    instr(3'd1, 0, 0, 0);
    instr(3'd4, 0, 0, 5);
    instr(3'd4, 1, 1, 0);
    instr(3'd5, 1, 0, 0);
    instr(3'd5, 0, 1, 0);
    instr(3'd6, 0, 1, 0);
    instr(3'd6, 1, 0, 0);
    instr(3'd0, 0, 0, 0);
    instr(3'd2, 0, 0, 0);
    instr(3'd3, 0, 0, 0);
    // random stream: any opcode but HALT, random flags and Enter every cycle
    for (int i = 0; i < 600; i++)
      cyc(0, 3'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), 1'($urandom));
    // bring the stream back to START, then reset and run 256 ADDs to wrap the counter
    for (int i = 0; i < 20 && m_state != 0; i++) cyc(0, 3'd2, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) instr(3'd2, 1'($urandom), 1'($urandom), 0);
    instr(3'd2, 0, 0, 0);
    // reset during DECODE
    cyc(0, 3'd1, 0, 0, 0);
    cyc(0, 3'd1, 0, 0, 0);
    cyc(1, 3'd1, 0, 0, 0);
    cyc(0, 3'd1, 0, 0, 0);
    // reset mid IN wait
    cyc(0, 0, 0, 0, 0);
    cyc(0, 3'd4, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    instr(3'd0, 0, 0, 0);
    // HALT absorbs for 20 cycles, then reset recovers
    instr(3'd7, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc(0, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
